// File: rtl/life_grid_renderer.sv
// Pixel renderer for the Game of Life array: gridlines, age-coloured cells and a blinking
// cursor, drawn from per-frame snapshots of the live state through a two-stage pixel pipeline.
module life_grid_renderer #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int CELL_LOG2    = 6,
    parameter int XPOS         = 100,
    parameter int YPOS         = 100,
    parameter int GRID_EN      = 1,
    parameter int AGE_BITS     = 2,
    parameter int BLINK_FRAMES = 30,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            x,
    input  logic [10:0]            y,
    input  logic                   frame,
    input  logic [ROWS*COLS-1:0]   alive,
    input  logic                   gen_step,
    input  logic [RW-1:0]          cursor_row,
    input  logic [CW-1:0]          cursor_col,
    input  logic                   cursor_en,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue
);

    localparam int N     = ROWS * COLS;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int X_END = XPOS + (COLS << CELL_LOG2);
    localparam int Y_END = YPOS + (ROWS << CELL_LOG2);
    localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [N-1:0][AGE_BITS-1:0] age_r;
    logic [N-1:0][AGE_BITS-1:0] age_snap_r;
    logic [N-1:0]               alive_snap_r;
    logic [BW-1:0]              blink_cnt_r;
    logic                       blink_on_r;

    logic [10:0] dx_s, dy_s, col_s, row_s;
    logic        in_grid_s, grid_s, cursor_hit_s;
    logic        s1_in_grid_r, s1_grid_r, s1_cursor_r;
    logic [10:0] s1_row_r, s1_col_r;

    logic [31:0]         cell_lin_s;
    logic [IW-1:0]       cell_idx_s;
    logic [AGE_BITS-1:0] age_s;
    logic [3:0]          age_px_s;
    logic [11:0]         rgb_s;
    logic [3:0]          red_r, green_r, blue_r;

    // Per-cell saturating age counters, advanced only on a generation step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_r <= '0;
        end else if (gen_step) begin
            for (int i = 0; i < N; i++) begin
                if (alive[i]) begin
                    if (age_r[i] != AGE_MAX) age_r[i] <= age_r[i] + 1'b1;
                end else begin
                    age_r[i] <= {AGE_BITS{1'b0}};
                end
            end
        end
    end

    // Frame snapshot; non-blocking read of age_r keeps pre-update ages on a coincident gen_step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_snap_r <= '0;
            age_snap_r   <= '0;
        end else if (frame) begin
            alive_snap_r <= alive;
            age_snap_r   <= age_r;
        end
    end

    // Cursor blink phase counter, stepped once per frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= 1'b1;
        end else if (frame) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= {BW{1'b0}};
                blink_on_r  <= ~blink_on_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 1'b1;
            end
        end
    end

    // Stage 1 geometry: grid membership, cell coordinates, gridline and cursor match
    always_comb begin
        dx_s      = x - 11'(XPOS);
        dy_s      = y - 11'(YPOS);
        col_s     = dx_s >> CELL_LOG2;
        row_s     = dy_s >> CELL_LOG2;
        in_grid_s = (32'(x) >= XPOS) && (32'(x) < X_END) &&
                    (32'(y) >= YPOS) && (32'(y) < Y_END);
        grid_s    = (dx_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}}) ||
                    (dy_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}});
        cursor_hit_s = cursor_en &&
                       (32'(cursor_row) < ROWS) && (32'(cursor_col) < COLS) &&
                       (row_s == 11'(cursor_row)) && (col_s == 11'(cursor_col));
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_in_grid_r <= 1'b0;
            s1_grid_r    <= 1'b0;
            s1_cursor_r  <= 1'b0;
            s1_row_r     <= 11'd0;
            s1_col_r     <= 11'd0;
        end else begin
            s1_in_grid_r <= in_grid_s;
            s1_grid_r    <= grid_s;
            s1_cursor_r  <= cursor_hit_s;
            s1_row_r     <= row_s;
            s1_col_r     <= col_s;
        end
    end

    // Stage 2 colour selection in priority order
    always_comb begin
        cell_lin_s = 32'(s1_row_r) * COLS + 32'(s1_col_r);
        if (s1_in_grid_r && (cell_lin_s < N)) begin
            cell_idx_s = IW'(cell_lin_s);
        end else begin
            cell_idx_s = {IW{1'b0}};
        end
        age_s    = age_snap_r[cell_idx_s];
        age_px_s = 4'(age_s) << (4 - AGE_BITS);
        if (!s1_in_grid_r) begin
            rgb_s = 12'h000;
        end else if (s1_cursor_r && blink_on_r) begin
            rgb_s = 12'hFFF;
        end else if ((GRID_EN != 0) && s1_grid_r) begin
            rgb_s = 12'h333;
        end else if (alive_snap_r[cell_idx_s]) begin
            rgb_s = {age_px_s, 4'hF - age_px_s, 4'h0};
        end else begin
            rgb_s = 12'h000;
        end
    end

    // Stage 2 registered colour outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red_r   <= 4'h0;
            green_r <= 4'h0;
            blue_r  <= 4'h0;
        end else begin
            red_r   <= rgb_s[11:8];
            green_r <= rgb_s[7:4];
            blue_r  <= rgb_s[3:0];
        end
    end

    assign red   = red_r;
    assign green = green_r;
    assign blue  = blue_r;

endmodule

// File: tb/tb_life_grid_renderer.sv
// Randomised bench for life_grid_renderer: a 4x4 and a 3x4 instance share stimulus and are
// compared against an arithmetic model of ages, snapshots, blink phase and pixel colour.
module tb_life_grid_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic        frame, gen_step, cursor_en;
    logic [15:0] alive;
    logic [1:0]  cursor_row, cursor_col;
    logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

    int tests_run = 0;
    int tests_failed = 0;

    int m_age[16];
    int m_snap_age[16];
    bit m_snap_alive[16];
    int m_blink_cnt;
    bit m_blink_on;

    always #5 clk = ~clk;

    life_grid_renderer #(.BLINK_FRAMES(2)) dut_a (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame(frame), .alive(alive),
        .gen_step(gen_step), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .cursor_en(cursor_en), .red(red_a), .green(green_a), .blue(blue_a));

    life_grid_renderer #(.ROWS(3), .BLINK_FRAMES(2)) dut_b (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame(frame), .alive(alive[11:0]),
        .gen_step(gen_step), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .cursor_en(cursor_en), .red(red_b), .green(green_b), .blue(blue_b));

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got rgb=%03h expected rgb=%03h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_age[i] = 0; m_snap_age[i] = 0; m_snap_alive[i] = 1'b0;
        end
        m_blink_cnt = 0;
        m_blink_on  = 1'b1;
    endtask

    // Snapshot and blink see the state before this cycle's age update.
    task automatic model_apply(input bit g, input bit f);
        if (f) begin
            for (int i = 0; i < 16; i++) begin
                m_snap_age[i]   = m_age[i];
                m_snap_alive[i] = alive[i];
            end
            m_blink_cnt++;
            if (m_blink_cnt == 2) begin
                m_blink_cnt = 0;
                m_blink_on  = !m_blink_on;
            end
        end
        if (g) begin
            for (int i = 0; i < 16; i++) m_age[i] = alive[i] ? ((m_age[i] < 3) ? m_age[i] + 1 : 3) : 0;
        end
    endtask

    function automatic logic [11:0] ref_rgb(input int px, input int py, input int rows);
        int r, c, idx;
        logic [3:0] rd;
        if (px < 100 || px >= 100 + 4 * 64 || py < 100 || py >= 100 + rows * 64) return 12'h000;
        c = (px - 100) / 64;
        r = (py - 100) / 64;
        idx = r * 4 + c;
        if (cursor_en && m_blink_on && cursor_row < rows && r == cursor_row && c == cursor_col)
            return 12'hFFF;
        if ((px - 100) % 64 == 0 || (py - 100) % 64 == 0) return 12'h333;
        if (m_snap_alive[idx]) begin
            rd = 4'(m_snap_age[idx] * 4);
            return {rd, 4'(15 - m_snap_age[idx] * 4), 4'h0};
        end
        return 12'h000;
    endfunction

    task automatic tick(input bit g, input bit f);
        gen_step = g;
        frame    = f;
        model_apply(g, f);
        @(negedge clk);
        gen_step = 1'b0;
        frame    = 1'b0;
    endtask

    task automatic check_pix(input string tag, input int px, input int py);
        x = 11'(px);
        y = 11'(py);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val({tag, "_a"}, {red_a, green_a, blue_a}, ref_rgb(px, py, 4));
        check_val({tag, "_b"}, {red_b, green_b, blue_b}, ref_rgb(px, py, 3));
    endtask

    initial begin
        reset = 1'b0; x = 11'd0; y = 11'd0; frame = 1'b0; gen_step = 1'b0;
        alive = 16'h0000; cursor_row = 2'd0; cursor_col = 2'd0; cursor_en = 1'b0;
        model_reset();

        // Reset held: random activity must not reach the outputs
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            x = 11'($urandom_range(0, 400)); y = 11'($urandom_range(0, 400));
            alive = 16'($urandom); frame = 1'($urandom); gen_step = 1'($urandom);
            cursor_en = 1'($urandom);
            #1;
            check_val("reset_hold_a", {red_a, green_a, blue_a}, 12'h000);
            check_val("reset_hold_b", {red_b, green_b, blue_b}, 12'h000);
        end
        @(negedge clk);
        alive = 16'h0000; frame = 1'b0; gen_step = 1'b0; cursor_en = 1'b0;
        x = 11'd0; y = 11'd0;
        reset = 1'b1;
        check_pix("reset_release", 0, 0);

        // Geometry and latency
        alive = 16'h0001;
        tick(1'b0, 1'b1);
        check_pix("geom_alive", 101, 101);
        check_pix("geom_gridline", 100, 120);
        check_pix("geom_dead", 165, 101);
        check_pix("geom_outside", 356, 101);

        // Ageing with saturation and clear
        alive = 16'h0020;
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check_pix("age3", 170, 170);
        check_val("age3_const", {red_a, green_a, blue_a}, 12'hC30);
        repeat (2) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check_pix("age_sat", 170, 170);
        alive = 16'h0000;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check_pix("age_clear", 170, 170);

        // Snapshot isolation
        alive = 16'hFFFF;
        check_pix("snap_hold", 101, 101);
        tick(1'b0, 1'b1);
        check_pix("snap_take", 101, 101);

        // Cursor blink on a gridline pixel inside cell (1,2)
        cursor_en = 1'b1; cursor_row = 2'd1; cursor_col = 2'd2;
        check_pix("blink0", 228, 200);
        repeat (2) tick(1'b0, 1'b1);
        check_pix("blink1", 228, 200);
        repeat (2) tick(1'b0, 1'b1);
        check_pix("blink2", 228, 200);
        cursor_row = 2'd3; cursor_col = 2'd3;
        check_pix("cursor_row3", 300, 300);
        check_pix("cursor_row3_in", 300, 250);

        // Coincident frame and gen_step
        cursor_en = 1'b0;
        alive = 16'h0001;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check_pix("coincide", 101, 101);
        check_val("coincide_const", {red_a, green_a, blue_a}, 12'h4B0);
        tick(1'b0, 1'b1);
        check_pix("coincide_next", 101, 101);
        check_val("coincide_next_const", {red_a, green_a, blue_a}, 12'h870);

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            alive = 16'($urandom);
            cursor_en = 1'($urandom); cursor_row = 2'($urandom); cursor_col = 2'($urandom);
            for (int k = 0; k < $urandom_range(1, 4); k++) tick(1'($urandom), 1'($urandom));
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 1) == 0)
                    check_pix("rand_pix", $urandom_range(80, 380), $urandom_range(80, 380));
                else
                    check_pix("rand_edge", 100 + 64 * $urandom_range(0, 4) + $urandom_range(0, 1),
                              100 + 64 * $urandom_range(0, 4) - $urandom_range(0, 1));
            end
        end

        // Mid-frame reset
        alive = 16'hFFFF;
        tick(1'b1, 1'b1);
        x = 11'd150; y = 11'd150;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midreset_a", {red_a, green_a, blue_a}, 12'h000);
        check_val("midreset_b", {red_b, green_b, blue_b}, 12'h000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        check_pix("midreset_release", 150, 150);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
